// File: rtl/ofdm_pkg.sv
// Purpose: shared OFDM constants, bin classification and data-to-bin mapping.
// Latency: n/a (types and pure functions only).
// Backpressure: n/a.
package ofdm_pkg;

  localparam int N_FFT  = 64;
  localparam int N_DATA = 48;

  typedef enum logic [1:0] {BIN_NULL, BIN_DATA, BIN_PILOT} bin_type_t;

  // DC and the guard band (|s| > 26) are null; four fixed pilot bins; the rest carry data.
  function automatic bin_type_t bin_type(input logic [5:0] bin);
    bin_type_t t;
    if (bin == 6'd0 || (bin >= 6'd27 && bin <= 6'd37)) begin
      t = BIN_NULL;
    end else if (bin == 6'd7 || bin == 6'd21 || bin == 6'd43 || bin == 6'd57) begin
      t = BIN_PILOT;
    end else begin
      t = BIN_DATA;
    end
    return t;
  endfunction

  // Data symbol k lands on subcarrier s = k - off, where off shrinks by one each time
  // a pilot or DC is skipped; the 6-bit subtraction wraps s into bin = s mod 64.
  function automatic logic [5:0] data_bin(input logic [5:0] k);
    logic [5:0] off;
    if (k < 6'd5) begin
      off = 6'd26;
    end else if (k < 6'd18) begin
      off = 6'd25;
    end else if (k < 6'd24) begin
      off = 6'd24;
    end else if (k < 6'd30) begin
      off = 6'd23;
    end else if (k < 6'd43) begin
      off = 6'd22;
    end else begin
      off = 6'd21;
    end
    return k - off;
  endfunction

  // Returns 1 when the pilot on this bin is -1 (only s = +21, bin 21); 0 means +1.
  function automatic logic pilot_sign(input logic [5:0] bin);
    return (bin == 6'd21);
  endfunction

endpackage

// File: rtl/subcarrier_mapper_if.sv
// Purpose: handshake bundle between QPSK source, subcarrier mapper and IFFT sink.
// Latency: n/a (wires only).
// Backpressure: in_valid/in_ready on the symbol side, out_valid/out_ready on the bin side.
interface subcarrier_mapper_if #(
  parameter int DATA_W = 32
);
  logic                     in_valid;
  logic                     in_ready;
  logic signed [DATA_W-1:0] in_real;
  logic signed [DATA_W-1:0] in_imag;
  logic                     out_valid;
  logic                     out_ready;
  logic signed [DATA_W-1:0] out_real;
  logic signed [DATA_W-1:0] out_imag;
  logic [5:0]               out_bin;
  logic                     out_last;

  modport master (
    output in_valid, in_real, in_imag, out_ready,
    input  in_ready, out_valid, out_real, out_imag, out_bin, out_last
  );

  modport slave (
    input  in_valid, in_real, in_imag, out_ready,
    output in_ready, out_valid, out_real, out_imag, out_bin, out_last
  );
endinterface

// File: rtl/subcarrier_mapper_pilot_lfsr.sv
// Purpose: per-frame pilot polarity from a 7-bit LFSR (x^7+x^4+1, seed all ones).
// Latency: polarity changes the cycle after adv_i.
// Backpressure: none; advances only when adv_i is high.
`ifdef PILOT_POLARITY_EN
module pilot_lfsr (
  input  logic clk,
  input  logic rst,
  input  logic adv_i,
  output logic pol_o
);
  logic [6:0] lfsr_q;
  logic [6:0] lfsr_d;

  // Shift left, feeding back the x^7 and x^4 taps; hold when not advancing.
  always_comb begin
    lfsr_d = lfsr_q;
    if (adv_i) begin
      lfsr_d = {lfsr_q[5:0], lfsr_q[6] ^ lfsr_q[3]};
    end
  end

  // State register, seeded with all ones so frame 0 uses the seed's output bit.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      lfsr_q <= 7'h7f;
    end else begin
      lfsr_q <= lfsr_d;
    end
  end

  // Output bit 1 means polarity -1.
  assign pol_o = lfsr_q[6];
endmodule
`endif

// File: rtl/subcarrier_mapper.sv
// Purpose: collect 48 data symbols, then stream 64 IFFT bins (data/pilot/null) in bin order; PILOT_POLARITY_EN adds LFSR pilot polarity.
// Latency: first bin valid 2 cycles after the 48th input handshake; 1 bin/cycle with out_ready high.
// Backpressure: out_* hold while out_valid && !out_ready; in_ready low for the whole drain.
module subcarrier_mapper #(
  parameter int DATA_W  = 32,
  parameter int PILOT_A = 80
) (
  input logic                clk,
  input logic                rst,
  subcarrier_mapper_if.slave bus
);
  import ofdm_pkg::*;

  typedef enum logic {FILL, DRAIN} state_t;

  localparam logic signed [DATA_W-1:0] PILOT_POS = DATA_W'(PILOT_A);
  localparam logic signed [DATA_W-1:0] PILOT_NEG = -PILOT_POS;

  state_t                   state_q, state_d;
  logic [5:0]               k_q, k_d;
  logic [6:0]               b_q, b_d;
  logic                     in_ready_q, in_ready_d;
  logic                     s1_vld_q, s1_vld_d;
  logic [5:0]               s1_bin_q;
  logic signed [DATA_W-1:0] s1_re_q, s1_im_q;
  logic                     out_vld_q, out_vld_d;
  logic                     out_last_q, out_last_d;
  logic [5:0]               out_bin_q, out_bin_d;
  logic signed [DATA_W-1:0] out_re_q, out_re_d;
  logic signed [DATA_W-1:0] out_im_q, out_im_d;
  logic signed [DATA_W-1:0] mem_re [N_FFT];
  logic signed [DATA_W-1:0] mem_im [N_FFT];
  logic                     in_hs, out_hs, out_load, s1_adv, issue, pol_neg;

  assign in_hs    = bus.in_valid && in_ready_q;
  assign out_hs   = out_vld_q && bus.out_ready;
  assign out_load = !out_vld_q || bus.out_ready;
  // Read stage moves when it is empty or its content is being taken by the output register.
  assign s1_adv   = !s1_vld_q || out_load;
  // b_q[6] set means all 64 bins have been read out of the buffer for this frame.
  assign issue    = (state_q == DRAIN) && s1_adv && !b_q[6];

`ifdef PILOT_POLARITY_EN
  pilot_lfsr u_pilot_lfsr (
    .clk   (clk),
    .rst   (rst),
    .adv_i (out_hs && out_last_q),
    .pol_o (pol_neg)
  );
`else
  assign pol_neg = 1'b0;
`endif

  // Next-state: count data symbols in FILL, count bins in DRAIN, return on the last-bin handshake.
  always_comb begin
    state_d = state_q;
    k_d     = k_q;
    b_d     = b_q;
    case (state_q)
      FILL: begin
        if (in_hs) begin
          if (k_q == 6'(N_DATA - 1)) begin
            k_d     = '0;
            state_d = DRAIN;
          end else begin
            k_d = k_q + 6'd1;
          end
        end
      end
      DRAIN: begin
        if (issue) begin
          b_d = b_q + 7'd1;
        end
        if (out_hs && out_last_q) begin
          state_d = FILL;
          b_d     = '0;
        end
      end
    endcase
    in_ready_d = (state_d == FILL);
    s1_vld_d   = s1_adv ? issue : s1_vld_q;
  end

  // Output stage: substitute pilot/null values for non-data bins as the bin is loaded.
  always_comb begin
    out_vld_d  = out_vld_q;
    out_last_d = out_last_q;
    out_bin_d  = out_bin_q;
    out_re_d   = out_re_q;
    out_im_d   = out_im_q;
    if (out_load) begin
      out_vld_d  = s1_vld_q;
      out_last_d = s1_vld_q && (s1_bin_q == 6'd63);
      if (s1_vld_q) begin
        out_bin_d = s1_bin_q;
        case (bin_type(s1_bin_q))
          BIN_DATA: begin
            out_re_d = s1_re_q;
            out_im_d = s1_im_q;
          end
          BIN_PILOT: begin
            out_re_d = (pilot_sign(s1_bin_q) ^ pol_neg) ? PILOT_NEG : PILOT_POS;
            out_im_d = '0;
          end
          default: begin
            out_re_d = '0;
            out_im_d = '0;
          end
        endcase
      end
    end
  end

  // Control and output registers.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q    <= FILL;
      k_q        <= '0;
      b_q        <= '0;
      in_ready_q <= 1'b0;
      s1_vld_q   <= 1'b0;
      out_vld_q  <= 1'b0;
      out_last_q <= 1'b0;
      out_bin_q  <= '0;
      out_re_q   <= '0;
      out_im_q   <= '0;
    end else begin
      state_q    <= state_d;
      k_q        <= k_d;
      b_q        <= b_d;
      in_ready_q <= in_ready_d;
      s1_vld_q   <= s1_vld_d;
      out_vld_q  <= out_vld_d;
      out_last_q <= out_last_d;
      out_bin_q  <= out_bin_d;
      out_re_q   <= out_re_d;
      out_im_q   <= out_im_d;
    end
  end

  // Read stage: one-cycle registered buffer read addressed by the bin counter.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      s1_bin_q <= '0;
      s1_re_q  <= '0;
      s1_im_q  <= '0;
    end else if (issue) begin
      s1_bin_q <= b_q[5:0];
      s1_re_q  <= mem_re[b_q[5:0]];
      s1_im_q  <= mem_im[b_q[5:0]];
    end
  end

  // Symbol buffer write; contents need no reset since every data bin is rewritten each frame.
  always_ff @(posedge clk) begin
    if (in_hs) begin
      mem_re[data_bin(k_q)] <= bus.in_real;
      mem_im[data_bin(k_q)] <= bus.in_imag;
    end
  end

  assign bus.in_ready  = in_ready_q;
  assign bus.out_valid = out_vld_q;
  assign bus.out_last  = out_last_q;
  assign bus.out_bin   = out_bin_q;
  assign bus.out_real  = out_re_q;
  assign bus.out_imag  = out_im_q;

endmodule
